// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_pkg
// Purpose  : Shared state encoding and default width for the bit-serial
//            subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Purpose  : Request/result bundle between a requester (master) and the
//            bit-serial subtractor (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, difference, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, difference, borrow
  );

endinterface
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Purpose  : Single-bit combinational full subtractor, d = a - b - bin.
// Revision : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  wire logic a,
  input  wire logic b,
  input  wire logic bin,
  output logic      bout,
  output logic      d
);

  // Difference bit and borrow-out of one bit position.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial unsigned subtractor, a - b, LSB first, one bit per
//            clock with a registered borrow chain and start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic          clock,
  input  wire logic          reset_n,
  serial_subtractor_if.slave bus
);

  // Counter must be able to reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   diff_q;
  logic               bin_q;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               cell_d;
  logic               cell_bout;
  logic               last_bit;
  logic [WIDTH-1:0]   res_d;

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .bout (cell_bout),
    .d    (cell_d)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // New result bit enters at the MSB so that after WIDTH shifts bit 0 is LSB.
  assign res_d    = {cell_d, res_q[WIDTH-1:1]};

  assign bus.difference = diff_q;
  assign bus.borrow     = borrow_q;

  // Next-state decode and state-derived handshake outputs.
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SHIFT;
      end
      SHIFT: begin
        bus.busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state plus operand, result, borrow and counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            res_q <= '0;
            bin_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          bin_q <= cell_bout;
          cnt_q <= cnt_q + CNT_W'(1);
          // Publish only on the final bit so outputs stay stable mid-operation.
          if (last_bit) begin
            diff_q   <= res_d;
            borrow_q <= cell_bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Directed self-checking bench for serial_subtractor at WIDTH=8
//            and WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic clk;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  logic        s_busy;
  logic        s_done;
  logic [31:0] s_diff;
  logic        s_borrow;

  serial_subtractor_if #(.WIDTH(8)) if8 ();
  serial_subtractor_if #(.WIDTH(4)) if4 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (if8.slave)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic sample(input int w);
    if (w == 4) begin
      s_busy   = if4.busy;
      s_done   = if4.done;
      s_diff   = {28'd0, if4.difference};
      s_borrow = if4.borrow;
    end else begin
      s_busy   = if8.busy;
      s_done   = if8.done;
      s_diff   = {24'd0, if8.difference};
      s_borrow = if8.borrow;
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [7:0] av, input logic [7:0] bv);
    if (w == 4) begin
      if4.start = st;
      if4.a     = av[3:0];
      if4.b     = bv[3:0];
    end else begin
      if8.start = st;
      if8.a     = av;
      if8.b     = bv;
    end
  endtask

  // One full operation: checks latency, busy length, result and done width.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        input logic [31:0] exp_diff, input logic exp_bw);
    int lat;
    int busy_cnt;
    bit got;
    @(negedge clk);
    drive(w, 1'b1, av, bv);
    @(posedge clk);
    #1;
    // Scramble operands after acceptance: they must already be captured.
    drive(w, 1'b0, ~av, ~bv);
    sample(w);
    busy_cnt = s_busy ? 1 : 0;
    lat      = -1;
    got      = 1'b0;
    for (int k = 1; k <= w + 4 && !got; k++) begin
      @(posedge clk);
      #1;
      sample(w);
      if (s_done) begin
        got = 1'b1;
        lat = k;
        check_value("busy_low_at_done", 32'(s_busy), 32'd0);
      end else if (s_busy) begin
        busy_cnt++;
      end
    end
    check_value("done_latency", 32'(lat), 32'(w));
    check_value("busy_cycles", 32'(busy_cnt), 32'(w));
    check_value("difference", s_diff, exp_diff);
    check_value("borrow", 32'(s_borrow), 32'(exp_bw));
    @(posedge clk);
    #1;
    sample(w);
    check_value("done_one_cycle", 32'(s_done), 32'd0);
    check_value("difference_held", s_diff, exp_diff);
  endtask

  initial begin
    int dones;
    int last;
    reset_n = 1'b0;
    drive(8, 1'b0, 8'd0, 8'd0);
    drive(4, 1'b0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    sample(8);
    check_value("reset_busy", 32'(s_busy), 32'd0);
    check_value("reset_done", 32'(s_done), 32'd0);
    check_value("reset_difference", s_diff, 32'd0);
    check_value("reset_borrow", 32'(s_borrow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic and extreme operands at WIDTH=8.
    run_op(8, 8'd100, 8'd37, 32'd63, 1'b0);
    run_op(8, 8'd255, 8'd255, 32'd0, 1'b0);
    run_op(8, 8'd0, 8'd1, 32'd255, 1'b1);
    run_op(8, 8'd5, 8'd9, 32'd252, 1'b1);

    // Start pulse during SHIFT must be ignored.
    @(negedge clk);
    drive(8, 1'b1, 8'd200, 8'd50);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 8'd0, 8'd0);
    dones = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      sample(8);
      if (k == 3) begin
        check_value("diff_stable_in_shift", s_diff, 32'd252);
        check_value("borrow_stable_in_shift", 32'(s_borrow), 32'd1);
        drive(8, 1'b1, 8'd1, 8'd1);
      end
      if (k == 4) drive(8, 1'b0, 8'd0, 8'd0);
      if (s_done) begin
        dones++;
        check_value("busy_start_difference", s_diff, 32'd150);
        check_value("busy_start_borrow", 32'(s_borrow), 32'd0);
      end
    end
    check_value("busy_start_done_count", 32'(dones), 32'd1);

    // Held start: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    drive(8, 1'b1, 8'd10, 8'd3);
    dones = 0;
    last  = -1;
    for (int k = 0; k < 34; k++) begin
      @(posedge clk);
      #1;
      sample(8);
      if (s_done) begin
        check_value("held_difference", s_diff, 32'd7);
        check_value("held_borrow", 32'(s_borrow), 32'd0);
        if (last >= 0) check_value("held_period", 32'(k - last), 32'd10);
        last = k;
        dones++;
      end
    end
    check_value("held_done_count", 32'(dones), 32'd3);
    @(negedge clk);
    drive(8, 1'b0, 8'd0, 8'd0);
    repeat (12) @(posedge clk);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    drive(8, 1'b1, 8'd9, 8'd2);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 8'd0, 8'd0);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    sample(8);
    check_value("abort_busy", 32'(s_busy), 32'd0);
    check_value("abort_done", 32'(s_done), 32'd0);
    check_value("abort_difference", s_diff, 32'd0);
    check_value("abort_borrow", 32'(s_borrow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      sample(8);
      if (s_done) dones++;
    end
    check_value("abort_no_done", 32'(dones), 32'd0);
    run_op(8, 8'd9, 8'd2, 32'd7, 1'b0);

    // Narrow instance: 3 - 12 wraps to 7 with borrow.
    run_op(4, 8'd3, 8'd12, 32'd7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
